// File: rtl/tpmem_pingpong.sv
// Ping-pong transpose memory between the row and column DCT passes: rows in,
// columns out, only the first KEEP lanes stored, remaining columns optionally zero.
module tpmem_pingpong #(
  parameter int BW        = 8,
  parameter int N         = 8,
  parameter int KEEP      = 6,
  parameter int ZERO_FILL = 1
) (
  input  logic            i_clk,
  input  logic            i_Reset,
  input  logic [N*BW-1:0] i_data,
  input  logic            i_en,
  output logic            o_in_ready,
  output logic [N*BW-1:0] o_data,
  output logic            o_en,
  input  logic            i_out_ready,
  output logic [1:0]      o_full_banks
);

  localparam int CW    = ($clog2(N) > 0) ? $clog2(N) : 1;
  localparam int BEATS = (ZERO_FILL != 0) ? N : KEEP;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_state_e;

  bank_state_e     bank_st [2];
  logic            wr_bank;
  logic            rd_bank;
  logic [CW-1:0]   wr_row;
  logic [CW-1:0]   rd_col;
  logic [BW-1:0]   mem [2][N][KEEP];
  logic [N*BW-1:0] col_data;
  logic            wr_fire;
  logic            wr_last;
  logic            rd_load;
  logic            rd_last;
  logic            unused_lanes;

  assign o_in_ready   = !i_Reset && (bank_st[wr_bank] == EMPTY);
  assign wr_fire      = i_en && o_in_ready;
  assign wr_last      = (wr_row == CW'(N - 1));
  assign rd_load      = !o_en || i_out_ready;
  assign rd_last      = (rd_col == CW'(BEATS - 1));
  assign o_full_banks = {1'b0, bank_st[0] == FULL} + {1'b0, bank_st[1] == FULL};
  // Lanes KEEP..N-1 are pruned on entry and never stored.
  assign unused_lanes = ^i_data;

  // NOTE: storage has no reset; its contents are don't-care until a row is written.
  always_ff @(posedge i_clk) begin
    if (wr_fire) begin
      for (int k = 0; k < KEEP; k++) begin
        mem[wr_bank][wr_row][k] <= i_data[(N-1-k)*BW +: BW];
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    col_data = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < KEEP; c++) begin
        if (rd_col == CW'(c)) begin
          col_data[(N-1-r)*BW +: BW] = mem[rd_bank][r][c];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_Reset) begin
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_row     <= '0;
      rd_col     <= '0;
      o_en       <= 1'b0;
      o_data     <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_last) begin
          bank_st[wr_bank] <= FULL;
          wr_bank          <= !wr_bank;
          wr_row           <= '0;
        end else begin
          wr_row <= wr_row + CW'(1);
        end
      end
      // A fill and a release always target different banks, so both may land on one edge.
      if (rd_load) begin
        if (bank_st[rd_bank] == FULL) begin
          o_en   <= 1'b1;
          o_data <= col_data;
          if (rd_last) begin
            bank_st[rd_bank] <= EMPTY;
            rd_bank          <= !rd_bank;
            rd_col           <= '0;
          end else begin
            rd_col <= rd_col + CW'(1);
          end
        end else begin
          o_en   <= 1'b0;
          o_data <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tpmem_pingpong.sv
// Scoreboard bench for tpmem_pingpong: instance a uses KEEP=6 with zero fill,
// instance b uses KEEP=4 without zero fill.
module tb_tpmem_pingpong;

  localparam int BW = 8;
  localparam int N  = 8;
  localparam int W  = N * BW;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a_data, a_out, b_data, b_out;
  logic         a_en, a_in_ready, a_oen, a_out_ready;
  logic         b_en, b_in_ready, b_oen, b_out_ready;
  logic [1:0]   a_full, b_full;

  int           errors = 0;
  int           checks = 0;
  int           stalls_a = 0;
  int           beats_a = 0, gaps_a = 0, beats_b = 0, gaps_b = 0;
  logic         prev_a = 1'b0, prev_b = 1'b0;
  logic [W-1:0] sb_a[$];
  logic [W-1:0] sb_b[$];

  always #5 clk = ~clk;

  tpmem_pingpong #(.BW(BW), .N(N), .KEEP(6), .ZERO_FILL(1)) dut_a (
    .i_clk(clk), .i_Reset(rst), .i_data(a_data), .i_en(a_en), .o_in_ready(a_in_ready),
    .o_data(a_out), .o_en(a_oen), .i_out_ready(a_out_ready), .o_full_banks(a_full)
  );

  tpmem_pingpong #(.BW(BW), .N(N), .KEEP(4), .ZERO_FILL(0)) dut_b (
    .i_clk(clk), .i_Reset(rst), .i_data(b_data), .i_en(b_en), .o_in_ready(b_in_ready),
    .o_data(b_out), .o_en(b_oen), .i_out_ready(b_out_ready), .o_full_banks(b_full)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] row_word(input int r, input int off);
    logic [W-1:0] w;
    for (int k = 0; k < N; k++) w[(N-1-k)*BW +: BW] = 8'(16 * r + k + off);
    return w;
  endfunction

  function automatic logic [W-1:0] col_word(input int c, input int off, input int keep);
    logic [W-1:0] w;
    for (int r = 0; r < N; r++) w[(N-1-r)*BW +: BW] = (c < keep) ? 8'(16 * r + c + off) : 8'h00;
    return w;
  endfunction

  // Output monitors: a beat is taken on the coming edge when o_en && ready at mid-cycle.
  always @(negedge clk) begin
    if (a_oen && a_out_ready) begin
      beats_a++;
      if (sb_a.size() == 0) check("a_sb_size", 64'(sb_a.size()), 64'd1);
      else                  check("a_col", a_out, sb_a.pop_front());
    end
    if (!rst && a_oen === 1'b0) check("a_idle_data", a_out, '0);
    if (!a_oen && prev_a && sb_a.size() > 0) gaps_a++;
    prev_a = a_oen;

    if (b_oen && b_out_ready) begin
      beats_b++;
      if (sb_b.size() == 0) check("b_sb_size", 64'(sb_b.size()), 64'd1);
      else                  check("b_col", b_out, sb_b.pop_front());
    end
    if (!rst && b_oen === 1'b0) check("b_idle_data", b_out, '0);
    if (!b_oen && prev_b && sb_b.size() > 0) gaps_b++;
    prev_b = b_oen;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input int off, input bit idle_gaps);
    for (int r = 0; r < N; r++) begin
      if (idle_gaps) begin
        a_en   = 1'b0;
        a_data = ~row_word(r, off);
        tick();
      end
      a_en   = 1'b1;
      a_data = row_word(r, off);
      for (int n = 0; n < 200 && !a_in_ready; n++) begin
        stalls_a++;
        tick();
      end
      check("a_in_ready_wait", 64'(a_in_ready), 64'd1);
      tick();
    end
    a_en = 1'b0;
    for (int c = 0; c < N; c++) sb_a.push_back(col_word(c, off, 6));
  endtask

  task automatic send_b(input int off);
    for (int r = 0; r < N; r++) begin
      b_en   = 1'b1;
      b_data = row_word(r, off);
      for (int n = 0; n < 200 && !b_in_ready; n++) tick();
      check("b_in_ready_wait", 64'(b_in_ready), 64'd1);
      tick();
    end
    b_en = 1'b0;
    for (int c = 0; c < 4; c++) sb_b.push_back(col_word(c, off, 4));
  endtask

  task automatic drain_a();
    for (int n = 0; n < 300 && sb_a.size() > 0; n++) tick();
    check("a_drain", 64'(sb_a.size()), 64'd0);
    tick();
  endtask

  task automatic drain_b();
    for (int n = 0; n < 300 && sb_b.size() > 0; n++) tick();
    check("b_drain", 64'(sb_b.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bs, gs;
    rst = 1'b1;
    a_en = 1'b0; a_data = '0; a_out_ready = 1'b1;
    b_en = 1'b0; b_data = '0; b_out_ready = 1'b0;
    tick();
    tick();
    check("rst_oen", 64'(a_oen), 64'd0);
    check("rst_data", a_out, '0);
    check("rst_full", 64'(a_full), 64'd0);
    check("rst_in_ready", 64'(a_in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", 64'(a_in_ready), 64'd1);
    tick();

    // Basic transpose
    bs = beats_a; gs = gaps_a;
    send_a(0, 1'b0);
    check("s1_oen_before", 64'(a_oen), 64'd0);
    tick();
    check("s1_oen_rise", 64'(a_oen), 64'd1);
    check("s1_col0", a_out, 64'h0010203040506070);
    for (int i = 0; i < 5; i++) tick();
    check("s1_col5", a_out, 64'h0515253545556575);
    tick();
    check("s1_col6", a_out, '0);
    drain_a();
    check("s1_beats", 64'(beats_a - bs), 64'd8);
    check("s1_gaps", 64'(gaps_a - gs), 64'd0);

    // Streaming four blocks
    bs = beats_a; gs = gaps_a; stalls_a = 0;
    for (int b = 0; b < 4; b++) send_a(8 * b, 1'b0);
    check("s2_stalls", 64'(stalls_a), 64'd0);
    drain_a();
    check("s2_beats", 64'(beats_a - bs), 64'd32);
    check("s2_gaps", 64'(gaps_a - gs), 64'd0);

    // Back-pressure
    bs = beats_a; gs = gaps_a;
    a_out_ready = 1'b0;
    send_a(0, 1'b0);
    tick();
    check("s3_oen", 64'(a_oen), 64'd1);
    check("s3_col0", a_out, 64'h0010203040506070);
    send_a(8, 1'b0);
    check("s3_full", 64'(a_full), 64'd2);
    check("s3_in_ready", 64'(a_in_ready), 64'd0);
    a_en = 1'b1;
    a_data = row_word(0, 128);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("s3_hold_data", a_out, 64'h0010203040506070);
      check("s3_hold_full", 64'(a_full), 64'd2);
      check("s3_hold_ready", 64'(a_in_ready), 64'd0);
    end
    a_data = row_word(0, 16);
    a_out_ready = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("s3_ready_return", 64'(a_in_ready), (i == 7) ? 64'd1 : 64'd0);
    end
    send_a(16, 1'b0);
    drain_a();
    check("s3_beats", 64'(beats_a - bs), 64'd24);
    check("s3_gaps", 64'(gaps_a - gs), 64'd0);

    // No zero fill, KEEP=4
    send_b(0);
    send_b(8);
    check("s4_full", 64'(b_full), 64'd2);
    check("s4_col0", b_out, 64'h0010203040506070);
    bs = beats_b; gs = gaps_b;
    b_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("s4_col3", b_out, 64'h0313233343536373);
    tick();
    check("s4_next_col0", b_out, 64'h0818283848586878);
    drain_b();
    check("s4_beats", 64'(beats_b - bs), 64'd8);
    check("s4_gaps", 64'(gaps_b - gs), 64'd0);

    // Reset mid-block and mid-output
    for (int r = 0; r < 4; r++) begin
      a_en = 1'b1;
      a_data = row_word(r, 32);
      tick();
    end
    a_en = 1'b0;
    rst = 1'b1;
    tick();
    check("s5a_oen", 64'(a_oen), 64'd0);
    check("s5a_full", 64'(a_full), 64'd0);
    check("s5a_in_ready", 64'(a_in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("s5a_ready_after", 64'(a_in_ready), 64'd1);
    tick();
    send_a(0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    check("s5b_col2", a_out, col_word(2, 0, 6));
    rst = 1'b1;
    tick();
    sb_a.delete();
    check("s5b_oen", 64'(a_oen), 64'd0);
    check("s5b_data", a_out, '0);
    check("s5b_full", 64'(a_full), 64'd0);
    check("s5b_in_ready", 64'(a_in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("s5b_ready_after", 64'(a_in_ready), 64'd1);
    tick();
    bs = beats_a;
    send_a(64, 1'b0);
    drain_a();
    check("s5_fresh_beats", 64'(beats_a - bs), 64'd8);

    // Idle input gaps
    bs = beats_a; gs = gaps_a;
    send_a(0, 1'b1);
    drain_a();
    check("s6_beats", 64'(beats_a - bs), 64'd8);
    check("s6_gaps", 64'(gaps_a - gs), 64'd0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
